// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU serial front end.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int FRAME_BYTES_DEFAULT = 60;
  localparam int IDX_W               = 7;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, baud counter and byte FSM.
// state | meaning
// IDLE  | line high (or waiting for it to return high after a break)
// START | half-bit wait, then confirm the start bit
// DATA  | sample 8 data bits, LSB first
// STOP  | sample stop bit, flag good byte or framing error
module uart_rx_byte
  import gpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       line_idle
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_TC = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_TC = BAUD_W'(CLKS_PER_BIT - 1);

  rx_state_t         state, state_next;
  logic              rx_meta, rxs;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              rearm_wait, rearm_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rearm_wait <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      rearm_wait <= rearm_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    rearm_next = rearm_wait;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        // After a break the line must go high again before a new start counts
        if (rearm_wait) begin
          if (rxs) rearm_next = 1'b0;
        end else if (!rxs) begin
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == HALF_TC) begin
          baud_next  = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == FULL_TC) begin
          baud_next  = '0;
          shift_next = {rxs, shift_reg[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == FULL_TC) begin
          baud_next  = '0;
          state_next = IDLE;
          if (rxs) begin
            byte_valid = 1'b1;
          end else begin
            stop_err   = 1'b1;
            rearm_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_data = shift_reg;
  assign line_idle = (state == IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame-level UART receiver: numbers good bytes within a scene frame and
// emits register-write, frame-complete and framing-error strobes.
module uart_frame_rx
  import gpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FRAME_BYTES  = FRAME_BYTES_DEFAULT,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [7:0]       read_data,
  output logic [IDX_W-1:0] idx,
  output logic             update_reg,
  output logic             pc_ready,
  output logic             frame_err
);

  localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_TC  = IDLE_W'(IDLE_LIMIT);

  logic [7:0]        byte_data;
  logic              byte_valid, stop_err, line_idle;
  logic [IDX_W-1:0]  byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .line_idle (line_idle)
  );

  assign timeout = line_idle && (byte_cnt != '0) && (idle_cnt == IDLE_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data  <= '0;
      idx        <= '0;
      update_reg <= 1'b0;
      pc_ready   <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      update_reg <= byte_valid;
      frame_err  <= stop_err;
      // Follows the write of the last index by exactly one cycle
      pc_ready   <= update_reg && (idx == LAST_IDX);

      if (byte_valid) begin
        read_data <= byte_data;
        idx       <= byte_cnt;
        byte_cnt  <= (byte_cnt == LAST_IDX) ? '0 : byte_cnt + 1'b1;
      end else if (stop_err || timeout) begin
        byte_cnt  <= '0;
      end

      if (!line_idle || byte_cnt == '0 || timeout) idle_cnt <= '0;
      else                                         idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx; a short bit period keeps the run brief.
module tb_uart_frame_rx;

  localparam int CPB = 16;
  localparam int FB  = 60;
  localparam int TB  = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] read_data;
  logic [6:0] idx;
  logic       update_reg, pc_ready, frame_err;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  int model_cnt = 0;
  int exp_pc = 0, exp_ferr = 0, seen_pc = 0, seen_ferr = 0;
  logic       prev_upd = 1'b0;
  logic [6:0] prev_idx = '0;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (FB),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .read_data (read_data),
    .idx       (idx),
    .update_reg(update_reg),
    .pc_ready  (pc_ready),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    logic [14:0] e;
    if (update_reg) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL update_unexpected got data=%h idx=%0d, required no strobe", read_data, idx);
      end else begin
        e = exp_q.pop_front();
        if ({read_data, idx} !== e) begin
          errors++;
          $display("FAIL byte got data=%h idx=%0d, required data=%h idx=%0d",
                   read_data, idx, e[14:7], e[6:0]);
        end
      end
    end
    if (pc_ready) begin
      seen_pc++;
      checks++;
      if (!(prev_upd && prev_idx == 7'(FB - 1))) begin
        errors++;
        $display("FAIL pc_ready_timing got prev_update=%0b prev_idx=%0d, required 1 and %0d",
                 prev_upd, prev_idx, FB - 1);
      end
    end
    if (frame_err) seen_ferr++;
    if (update_reg || pc_ready || frame_err) begin
      checks++;
      if (int'(update_reg) + int'(pc_ready) + int'(frame_err) > 1) begin
        errors++;
        $display("FAIL strobe_exclusive got upd=%0b pc=%0b ferr=%0b, required at most one",
                 update_reg, pc_ready, frame_err);
      end
    end
    prev_upd = update_reg;
    prev_idx = idx;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1);
    if (stop_bit) begin
      exp_q.push_back({d, 7'(model_cnt)});
      if (model_cnt == FB - 1) exp_pc++;
      model_cnt = (model_cnt + 1) % FB;
    end else begin
      exp_ferr++;
      model_cnt = 0;
    end
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    if (n > TB) model_cnt = 0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 4 * CPB) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (seen_pc !== exp_pc) begin
      errors++;
      $display("FAIL %s_pc_count got %0d, required %0d", name, seen_pc, exp_pc);
      seen_pc = exp_pc;
    end
    checks++;
    if (seen_ferr !== exp_ferr) begin
      errors++;
      $display("FAIL %s_frame_err_count got %0d, required %0d", name, seen_ferr, exp_ferr);
      seen_ferr = exp_ferr;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (read_data !== 8'h00) begin errors++; $display("FAIL %s_read_data got %h, required 00", name, read_data); end
    checks++;
    if (idx !== 7'd0) begin errors++; $display("FAIL %s_idx got %0d, required 0", name, idx); end
    checks++;
    if (update_reg !== 1'b0) begin errors++; $display("FAIL %s_update_reg got %b, required 0", name, update_reg); end
    checks++;
    if (pc_ready !== 1'b0) begin errors++; $display("FAIL %s_pc_ready got %b, required 0", name, pc_ready); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL %s_frame_err got %b, required 0", name, frame_err); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_full_frame();
    for (int n = 0; n < FB; n++) send_byte(8'(n));
    drain("full_frame");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    drain("glitch_quiet");
    send_byte(8'hA5);
    drain("glitch_next");
  endtask

  task automatic test_frame_error();
    for (int n = 0; n < 3; n++) send_byte(8'(n));
    send_byte(8'h03, 1'b0);
    idle_bits(1);
    send_byte(8'h55);
    drain("frame_error");
  endtask

  task automatic test_timeout();
    idle_bits(TB + 1);
    for (int n = 0; n < 10; n++) send_byte(8'h10 + 8'(n));
    idle_bits(TB + 1);
    send_byte(8'h77);
    idle_bits(TB + 1);
    for (int n = 0; n < 10; n++) send_byte(8'h20 + 8'(n));
    idle_bits(TB - 1);
    send_byte(8'h77);
    drain("timeout");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h5A;
    idle_bits(TB + 1);
    for (int n = 0; n < 20; n++) send_byte(8'h80 + 8'(n));
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    rx = d[4];
    repeat (CPB / 2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending got %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    idle_bits(2);
    for (int n = 0; n < FB; n++) send_byte(8'(n) ^ 8'hFF);
    drain("reset_mid_frame");
  endtask

  task automatic test_break();
    rx = 1'b0;
    exp_ferr++;
    model_cnt = 0;
    repeat (20 * CPB) @(posedge clk);
    rx = 1'b1;
    idle_bits(2);
    send_byte(8'h3C);
    drain("break");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_glitch();
    test_frame_error();
    test_timeout();
    test_reset_mid_frame();
    test_break();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion within time limit, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
